// File: rtl/rx_sym_sync_if.sv
// rx_sym_sync_if: sample-in / decision-out bundle of the receive symbol synchroniser
interface rx_sym_sync_if #(
    parameter int UPSAMPLE = 4,
    parameter int IN_NBITS = 8
);
    localparam int PW = $clog2(UPSAMPLE);
    logic                enable;
    logic [IN_NBITS-1:0] rx_in;
    logic                phase_mode;
    logic [PW-1:0]       phase_manual;
    logic                rx_out;
    logic                rx_valid;
    logic [PW-1:0]       phase_sel;
    logic                locked;
    modport master (
        output enable, rx_in, phase_mode, phase_manual,
        input  rx_out, rx_valid, phase_sel, locked
    );
    modport slave (
        input  enable, rx_in, phase_mode, phase_manual,
        output rx_out, rx_valid, phase_sel, locked
    );
endinterface

// File: rtl/rx_sym_sync.sv
// rx_sym_sync: picks the sampling phase with the most accumulated |x| per window and slices one bit per symbol
module rx_sym_sync #(
    parameter int UPSAMPLE = 4,
    parameter int IN_NBITS = 8,
    parameter int IN_FBITS = 7,
    parameter int ACC_LOG2 = 10
) (
    input logic         clk,
    input logic         rst,
    rx_sym_sync_if.slave bus
);
    localparam int PW        = $clog2(UPSAMPLE);
    localparam int AW        = IN_NBITS - 1;
    localparam int ACC_NBITS = AW + ACC_LOG2;
    localparam int MSB       = IN_NBITS - 1;

    if (UPSAMPLE < 2 || (UPSAMPLE & (UPSAMPLE - 1)) != 0 || IN_FBITS >= IN_NBITS || ACC_LOG2 < 1) begin : g_bad_param
        $error("rx_sym_sync: invalid parameters");
    end

    typedef enum logic [1:0] {IDLE_ACC, COMPARE, UPDATE} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        cnt_q, cnt_d;
    logic [ACC_LOG2-1:0]  sym_cnt_q, sym_cnt_d;
    logic [ACC_NBITS-1:0] acc_q [UPSAMPLE];
    logic [ACC_NBITS-1:0] acc_d [UPSAMPLE];
    logic [ACC_NBITS-1:0] snap_q [UPSAMPLE];
    logic [ACC_NBITS-1:0] snap_d [UPSAMPLE];
    logic [ACC_NBITS-1:0] best_q, best_d;
    logic [PW-1:0]        best_idx_q, best_idx_d;
    logic [PW-1:0]        idx_q, idx_d;
    logic [PW-1:0]        phase_auto_q, phase_auto_d;
    logic [PW-1:0]        phase_sel_q, phase_sel_d;
    logic                 locked_q, locked_d;
    logic                 rx_out_q, rx_out_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [IN_NBITS-1:0]  neg_x;
    logic [AW-1:0]        abs_x;
    logic                 sym_end, win_end, fire;

    // Most-negative input negates onto itself; clamp it to the largest magnitude
    assign neg_x   = -bus.rx_in;
    assign abs_x   = !bus.rx_in[MSB] ? bus.rx_in[AW-1:0] : neg_x[MSB] ? {AW{1'b1}} : neg_x[AW-1:0];
    assign sym_end = bus.enable && cnt_q == PW'(UPSAMPLE - 1);
    assign win_end = sym_end && sym_cnt_q == {ACC_LOG2{1'b1}};
    assign fire    = bus.enable && cnt_q == phase_sel_q;

    always_comb begin
        cnt_d        = bus.enable ? cnt_q + 1'b1 : cnt_q;
        sym_cnt_d    = sym_end ? sym_cnt_q + 1'b1 : sym_cnt_q;
        state_d      = state_q;
        idx_d        = idx_q;
        best_d       = best_q;
        best_idx_d   = best_idx_q;
        phase_auto_d = phase_auto_q;
        locked_d     = locked_q;
        for (int p = 0; p < UPSAMPLE; p++) begin
            acc_d[p]  = win_end ? '0 : (bus.enable && cnt_q == PW'(p)) ? acc_q[p] + ACC_NBITS'(abs_x) : acc_q[p];
            snap_d[p] = win_end ? acc_q[p] + (cnt_q == PW'(p) ? ACC_NBITS'(abs_x) : '0) : snap_q[p];
        end
        case (state_q)
            IDLE_ACC: begin
                if (win_end) begin
                    state_d    = COMPARE;
                    idx_d      = '0;
                    best_d     = '0;
                    best_idx_d = '0;
                end
            end
            COMPARE: begin
                // Strict compare keeps the lowest index on ties
                if (snap_q[idx_q] > best_q) begin
                    best_d     = snap_q[idx_q];
                    best_idx_d = idx_q;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == PW'(UPSAMPLE - 1)) state_d = UPDATE;
            end
            UPDATE: begin
                phase_auto_d = best_idx_q;
                locked_d     = 1'b1;
                state_d      = IDLE_ACC;
            end
            default: state_d = IDLE_ACC;
        endcase
        phase_sel_d = bus.phase_mode ? bus.phase_manual : phase_auto_q;
        rx_valid_d  = fire;
        rx_out_d    = fire ? ~bus.rx_in[MSB] : rx_out_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE_ACC;
            cnt_q        <= '0;
            sym_cnt_q    <= '0;
            best_q       <= '0;
            best_idx_q   <= '0;
            idx_q        <= '0;
            phase_auto_q <= '0;
            phase_sel_q  <= '0;
            locked_q     <= 1'b0;
            rx_out_q     <= 1'b0;
            rx_valid_q   <= 1'b0;
            for (int p = 0; p < UPSAMPLE; p++) begin
                acc_q[p]  <= '0;
                snap_q[p] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sym_cnt_q    <= sym_cnt_d;
            best_q       <= best_d;
            best_idx_q   <= best_idx_d;
            idx_q        <= idx_d;
            phase_auto_q <= phase_auto_d;
            phase_sel_q  <= phase_sel_d;
            locked_q     <= locked_d;
            rx_out_q     <= rx_out_d;
            rx_valid_q   <= rx_valid_d;
            for (int p = 0; p < UPSAMPLE; p++) begin
                acc_q[p]  <= acc_d[p];
                snap_q[p] <= snap_d[p];
            end
        end
    end

    assign bus.rx_out    = rx_out_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.phase_sel = phase_sel_q;
    assign bus.locked    = locked_q;
endmodule

// File: tb/tb_rx_sym_sync.sv
// tb_rx_sym_sync: directed checks of reset, manual slicing, auto phase search, ties and aborted search
module tb_rx_sym_sync;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    rx_sym_sync_if #(.UPSAMPLE(4), .IN_NBITS(8)) sif ();

    rx_sym_sync #(.UPSAMPLE(4), .IN_NBITS(8), .IN_FBITS(7), .ACC_LOG2(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic en, input logic [7:0] x);
        @(negedge clk);
        sif.enable = en;
        sif.rx_in  = x;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b0;
        sif.enable = 1'b0;
        sif.rx_in  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [7:0] sample(input int mode, input int i);
        if (mode == 1) return 8'h80;
        if (i % 4 == 3) return ((i / 4) % 2) ? 8'(-100) : 8'(100);
        return (i % 2) ? 8'(10) : 8'(-10);
    endfunction

    // One full 16-symbol window from reset: decisions fall on phase 0 until lock
    task automatic run_window(input int mode);
        logic [7:0] x;
        for (int i = 0; i < 64; i++) begin
            x = sample(mode, i);
            step(1'b1, x);
            check("win_valid", int'(sif.rx_valid), int'(i % 4 == 0));
            if (i % 4 == 0) check("win_out", int'(sif.rx_out), int'(!x[7]));
        end
    endtask

    task automatic expect_lock(input int ph);
        repeat (4) step(1'b0, 8'h00);
        check("lock_early", int'(sif.locked), 0);
        step(1'b0, 8'h00);
        check("lock", int'(sif.locked), 1);
        check("phase_lag", int'(sif.phase_sel), 0);
        step(1'b0, 8'h00);
        check("phase_sel", int'(sif.phase_sel), ph);
    endtask

    initial begin
        logic [7:0] x;
        sif.enable       = 1'b0;
        sif.rx_in        = '0;
        sif.phase_mode   = 1'b0;
        sif.phase_manual = '0;

        for (int i = 0; i < 4; i++) step(i[0], 8'h40);
        check("rst_out", int'(sif.rx_out), 0);
        check("rst_valid", int'(sif.rx_valid), 0);
        check("rst_phase", int'(sif.phase_sel), 0);
        check("rst_locked", int'(sif.locked), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h40);
            check("idle_valid", int'(sif.rx_valid), 0);
        end

        do_reset();
        sif.phase_mode   = 1'b1;
        sif.phase_manual = 2'd2;
        step(1'b0, 8'h00);
        check("man_phase", int'(sif.phase_sel), 2);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i % 4 == 2) ? 8'(64) : 8'(-64));
            check("man_valid", int'(sif.rx_valid), int'(i % 4 == 2));
            if (i % 4 == 2) check("man_out1", int'(sif.rx_out), 1);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(-64));
            if (i % 4 == 2) check("man_out0", int'(sif.rx_out), 0);
        end
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        check("zero_out", int'(sif.rx_out), 1);

        do_reset();
        sif.phase_mode = 1'b0;
        run_window(0);
        expect_lock(3);
        check("snap0", int'(dut.snap_q[0]), 160);
        check("snap1", int'(dut.snap_q[1]), 160);
        check("snap2", int'(dut.snap_q[2]), 160);
        check("snap3", int'(dut.snap_q[3]), 1600);
        for (int i = 0; i < 8; i++) begin
            x = (i % 4 == 3) ? ((i < 4) ? 8'(100) : 8'(-100)) : 8'(-10);
            step(1'b1, x);
            check("lock_valid", int'(sif.rx_valid), int'(i % 4 == 3));
            if (i % 4 == 3) check("lock_out", int'(sif.rx_out), int'(i < 4));
        end

        do_reset();
        run_window(1);
        expect_lock(0);
        for (int p = 0; p < 4; p++) check("snap_sat", int'(dut.snap_q[p]), 2032);
        check("sat_out", int'(sif.rx_out), 0);

        do_reset();
        run_window(0);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_locked", int'(sif.locked), 0);
        check("abort_phase", int'(sif.phase_sel), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8) step(1'b0, 8'h00);
        check("abort_stay", int'(sif.locked), 0);
        check("abort_stay_ph", int'(sif.phase_sel), 0);
        run_window(0);
        expect_lock(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
